mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one booth_mult instance among NUM_REQ requesters. It accepts signed operand pairs over per-requester valid/ready handshakes and drives the multiplier's en/A/B until done. It returns each product with the requester's ID over a single valid/ready response channel. It sits between the client blocks and booth_mult, so the multiplier never sees overlapping requests.

---
 rtl/mult_arb_pkg.sv | 28 ++
 rtl/mult_arbiter_checker.sv | 28 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/mult_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mult_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state codes,
// default parameter values and a ceil(log2) helper used to size the ID field.
package mult_arb_pkg;

  // FSM state encodings (kept as plain constants for legacy tool flows)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Default configuration
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 64;

  // Number of bits needed to encode values 0..value-1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_arbiter_checker.sv
// Protocol checker for mult_arbiter: requesters must hold valid until they
// are served, and the arbiter must never offer more than one grant or grant
// while a multiplication or response is outstanding.
module mult_arbiter_checker #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               busy
);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i])
      else $error("requester %0d withdrew valid before being served", i);
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready))
    else $error("more than one requester granted");

  a_ready_idle: assert property (@(posedge clk) disable iff (rst)
    busy |-> (req_ready == {NUM_REQ{1'b0}}))
    else $error("grant offered while busy");

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant logic. The search starts one slot above the
// previous winner and wraps once around the request vector; the caller owns
// the pointer register.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any
);

  // Rotating-priority scan: first active request above the last winner wins
  always_comb begin
    logic [ID_W-1:0] w_idx;
    logic            w_found;
    o_grant_oh  = {NUM_REQ{1'b0}};
    o_grant_idx = {ID_W{1'b0}};
    w_found     = 1'b0;
    w_idx       = {ID_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(i_last) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found            = 1'b1;
        o_grant_oh[w_idx]  = 1'b1;
        o_grant_idx        = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares a single booth_mult among NUM_REQ
// requesters. One operation is in flight at a time: IDLE grants, ISSUE holds
// the multiplier enabled until done, RESP presents the product with its owner.
// Optional build macro: MULT_ARB_TIMEOUT_EN adds a watchdog that abandons an
// operation after TIMEOUT ISSUE cycles and reports it through rsp_err.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(DEF_NUM_REQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [2*WIDTH-1:0]         rsp_m,
  output logic                       rsp_err,
  output logic                       mult_en,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic                       mult_done,
  input  logic [2*WIDTH-1:0]         mult_m,
  output logic                       busy
);

  // Elaboration-time sanity checks on the configuration
  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
    $error("mult_arbiter: NUM_REQ must be in 2..8");
  end
  if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
    $error("mult_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mult_arbiter: TIMEOUT must be at least 1");
  end

  logic [1:0]           r_state;
  logic [ID_W-1:0]      r_last;
  logic                 r_mult_en;
  logic [WIDTH-1:0]     r_mult_a;
  logic [WIDTH-1:0]     r_mult_b;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [2*WIDTH-1:0]   r_rsp_m;

  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [ID_W-1:0]      w_grant_idx;
  logic                 w_any;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_sel_a;
  logic [WIDTH-1:0]     w_sel_b;
  logic                 w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req       (req_valid),
    .i_last      (r_last),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // A grant is only offered from IDLE; reset forces the grant off at once
  assign w_accept = (r_state == ST_IDLE) && w_any && !rst;

  // Present the grant to the winning requester in the same cycle
  always_comb begin
    if (w_accept) begin
      req_ready = w_grant_oh;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // One-hot mux of the winner's operand slices
  always_comb begin
    w_sel_a = {WIDTH{1'b0}};
    w_sel_b = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_oh[k]) begin
        w_sel_a = req_a[k*WIDTH +: WIDTH];
        w_sel_b = req_b[k*WIDTH +: WIDTH];
      end else begin
        w_sel_a = w_sel_a;
        w_sel_b = w_sel_b;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_rsp_err;

  // Watchdog fires on the TIMEOUT-th ISSUE cycle if the multiplier is silent
  assign w_timeout = (r_state == ST_ISSUE) && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Count ISSUE cycles, restarting from zero on every new grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_ISSUE) && !w_timeout) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  // Error flag accompanies an abandoned operation until its response is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if ((r_state == ST_ISSUE) && !mult_done && w_timeout) begin
      r_rsp_err <= 1'b1;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= r_rsp_err;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // Main sequencer: grant, drive the multiplier, then hold the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_mult_en   <= 1'b0;
      r_mult_a    <= {WIDTH{1'b0}};
      r_mult_b    <= {WIDTH{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= {ID_W{1'b0}};
      r_rsp_m     <= {(2*WIDTH){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last    <= w_grant_idx;
            r_mult_a  <= w_sel_a;
            r_mult_b  <= w_sel_b;
            r_mult_en <= 1'b1;
            r_state   <= ST_ISSUE;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (mult_done) begin
            r_rsp_m     <= mult_m;
            r_rsp_id    <= r_last;
            r_mult_en   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_m     <= {(2*WIDTH){1'b0}};
            r_rsp_id    <= r_last;
            r_mult_en   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_state     <= ST_ISSUE;
          end
        end
        ST_RESP: begin
          // Returning to IDLE (not granting) keeps mult_en low for two cycles
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_RESP;
          end
        end
        default: begin
          r_mult_en   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mult_en   = r_mult_en;
  assign mult_a    = r_mult_a;
  assign mult_b    = r_mult_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_m     = r_rsp_m;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural booth_mult stand-in.
module tb_mult_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_m;
  logic           rsp_err;
  logic           mult_en;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic           mult_done;
  logic [2*W-1:0] mult_m;
  logic           busy;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_m(rsp_m), .rsp_err(rsp_err), .mult_en(mult_en),
    .mult_a(mult_a), .mult_b(mult_b), .mult_done(mult_done), .mult_m(mult_m),
    .busy(busy)
  );

  mult_arbiter_checker #(.NUM_REQ(N)) u_chk (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .busy(busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] m;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   model_last  = N - 1;
  int   pushes      = 0;
  int   rsp_count   = 0;
  int   en_rises    = 0;
  bit   hold        = 1'b0;
  bit   no_done     = 1'b0;
  bit   tmo_mode    = 1'b0;
  int   force_d     = 0;
  logic signed [7:0] op_a [N];
  logic signed [7:0] op_b [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: all masked requesters stay valid, so they are served in
  // rotating order starting after the previous winner.
  task automatic model_push(input logic [3:0] mask);
    logic [3:0] pend;
    logic [1:0] idx;
    bit         found;
    exp_t       e;
    int         prod;
    pend = mask;
    while (pend != 4'b0000) begin
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= N; k++) begin
        if (!found) begin
          idx = 2'((model_last + k) % N);
          if (pend[idx]) found = 1'b1;
        end
      end
      pend[idx]  = 1'b0;
      model_last = int'(idx);
      prod  = int'(op_a[idx]) * int'(op_b[idx]);
      e.id  = idx;
      e.a   = op_a[idx];
      e.b   = op_b[idx];
      e.m   = tmo_mode ? 16'h0000 : prod[15:0];
      e.err = tmo_mode;
      exp_q.push_back(e);
      pushes++;
    end
  endtask

  task automatic run_batch(input logic [3:0] mask);
    logic [3:0] seen;
    int base, need, g;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    model_push(mask);
    base = rsp_count;
    need = $countones(mask);
    req_valid = mask;
    g = 0;
    while ((req_valid != 4'b0000 || (rsp_count - base) < need) && g < 3000) begin
      #1;
      seen = req_valid & req_ready;
      @(negedge clk);
      req_valid = req_valid & ~seen;
      g++;
    end
    if (g >= 3000) begin
      chk("batch_timeout", 32'(rsp_count - base), 32'(need));
      req_valid = 4'b0000;
    end
  endtask

  // Behavioural booth_mult: done after a random latency, stray done pulses while idle
  initial begin
    int cnt;
    int d;
    mult_done = 1'b0;
    mult_m    = 16'h0000;
    cnt = 0;
    d   = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        mult_done = 1'b0;
        cnt = 0;
      end else if (mult_done) begin
        mult_done = 1'b0;
        cnt = 0;
      end else if (mult_en) begin
        if (cnt == 0) d = (force_d > 0) ? force_d : int'($urandom_range(1, 6));
        cnt++;
        if (cnt >= d && !no_done) begin
          mult_done = 1'b1;
          mult_m    = $signed(mult_a) * $signed(mult_b);
        end
      end else begin
        cnt = 0;
        if (!no_done && $urandom_range(0, 3) == 0) begin
          mult_done = 1'b1;
          mult_m    = 16'($urandom);
        end
      end
    end
  end

  // Response consumer and scoreboard monitor
  initial begin
    bit          prev_en, prev_stall;
    logic [15:0] prev_m;
    logic [1:0]  prev_id;
    logic [3:0]  oh;
    int          low_run, en_hi;
    exp_t        e;
    prev_en = 1'b0; prev_stall = 1'b0; prev_m = 16'h0; prev_id = 2'd0;
    low_run = 99; en_hi = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      #2;
      if (rst) begin
        prev_en = 1'b0; prev_stall = 1'b0; low_run = 99; en_hi = 0;
      end else begin
        chk("busy", 32'(busy), 32'(mult_en | rsp_valid));
        if (busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
        if (req_ready != 4'b0000) begin
          if (exp_q.size() == 0) chk("grant_unexpected", 32'(req_ready), 32'd0);
          else begin
            oh = 4'b0001 << exp_q[0].id;
            chk("grant", 32'(req_ready), 32'(oh));
          end
        end
        if (mult_en && !prev_en) begin
          en_rises++;
          chk("en_gap_ok", 32'(low_run >= 2), 32'd1);
          if (exp_q.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
          else begin
            chk("mult_a", 32'(mult_a), 32'(exp_q[0].a));
            chk("mult_b", 32'(mult_b), 32'(exp_q[0].b));
          end
        end
        if (mult_en) begin
          low_run = 0;
          en_hi++;
        end else begin
          low_run++;
          if (prev_en && tmo_mode) chk("tmo_cycles", 32'(en_hi), 32'(TMO));
          en_hi = 0;
        end
        if (rsp_valid) chk("en_in_resp", 32'(mult_en), 32'd0);
        if (rsp_valid && prev_stall) begin
          chk("stall_m", 32'(rsp_m), 32'(prev_m));
          chk("stall_id", 32'(rsp_id), 32'(prev_id));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_m", 32'(rsp_m), 32'(e.m));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
          rsp_count++;
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_m     = rsp_m;
        prev_id    = rsp_id;
        prev_en    = mult_en;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int g;
    rst = 1'b1;
    req_valid = 4'b0000;
    req_a = 32'h0;
    req_b = 32'h0;
    for (int i = 0; i < N; i++) begin op_a[i] = 8'sd0; op_b[i] = 8'sd0; end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mult_en", 32'(mult_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_m", 32'(rsp_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four together: rotation from 3 gives 0,1,2,3
    op_a[0] = 8'sd1;   op_b[0] = 8'sd1;
    op_a[1] = 8'sd10;  op_b[1] = -8'sd5;
    op_a[2] = 8'sd5;   op_b[2] = 8'sd8;
    op_a[3] = 8'sd100; op_b[3] = 8'sd127;
    run_batch(4'b1111);
    run_batch(4'b0101);

    // Single requester
    op_a[0] = -8'sd10; op_b[0] = -8'sd100;
    run_batch(4'b0001);
    op_a[0] = 8'sd1; op_b[0] = -8'sd1;
    run_batch(4'b0001);

    // Corner operands
    op_a[1] = -8'sd128; op_b[1] = -8'sd128;
    op_a[2] = -8'sd128; op_b[2] = 8'sd127;
    run_batch(4'b0110);

    // Backpressure: first response held for five cycles with req1 waiting
    op_a[0] = 8'sd7;  op_b[0] = 8'sd6;
    op_a[1] = -8'sd3; op_b[1] = 8'sd11;
    hold = 1'b1;
    fork
      run_batch(4'b0011);
      begin
        g = 0;
        while (!rsp_valid && g < 500) begin @(negedge clk); #3; g++; end
        if (g >= 500) chk("bp_rsp_seen", 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        #1 hold = 1'b0;
      end
    join

    // Reset during ISSUE discards the operation
    force_d = 40;
    op_a[3] = 8'sd25; op_b[3] = -8'sd3;
    @(negedge clk);
    req_a[3*W +: W] = op_a[3];
    req_b[3*W +: W] = op_b[3];
    model_push(4'b1000);
    req_valid = 4'b1000;
    g = 0;
    #1;
    while (!req_ready[3] && g < 200) begin @(negedge clk); #1; g++; end
    if (g >= 200) chk("rst_test_grant", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_rsp_m", 32'(rsp_m), 32'd0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("mid_rst_mult_en", 32'(mult_en), 32'd0);
    chk("mid_rst_mult_a", 32'(mult_a), 32'd0);
    chk("mid_rst_mult_b", 32'(mult_b), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    model_last = N - 1;
    force_d = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    op_a[2] = -8'sd7; op_b[2] = 8'sd9;
    run_batch(4'b0100);

    // Randomised batches
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = 8'($urandom);
        op_b[i] = 8'($urandom);
      end
      run_batch(4'($urandom_range(1, 15)));
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // Silent multiplier: abandoned after TIMEOUT cycles with an error response
    tmo_mode = 1'b1;
    no_done  = 1'b1;
    op_a[2] = 8'sd3; op_b[2] = 8'sd4;
    run_batch(4'b0100);
    tmo_mode = 1'b0;
    no_done  = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("en_rises", 32'(en_rises), 32'(pushes));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
